// File: rtl/led_pattern_ctrl.sv
// Multi-channel LED pattern generator: a shared prescaler tick drives per-channel off/on/blink/burst patterns.
// All outputs are registered; a mode change restarts the channel one cycle later and overrides tick/start.
module led_pattern_ctrl #(
  parameter int NCH     = 8,
  parameter int PRESC_W = 16,
  parameter int HP_W    = 4,
  parameter int BC_W    = 4
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [2*NCH-1:0]     mode,
  input  logic [HP_W*NCH-1:0]  half_period,
  input  logic [BC_W*NCH-1:0]  burst_cnt,
  input  logic [NCH-1:0]       start,
  output logic [NCH-1:0]       busy,
  output logic [NCH-1:0]       led,
  output logic                 tick
);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

  localparam logic [1:0] M_OFF   = 2'b00;
  localparam logic [1:0] M_ON    = 2'b01;
  localparam logic [1:0] M_BLINK = 2'b10;

  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] presc_nxt;

  assign presc_nxt = presc + PRESC_W'(1);

  // tick is registered so it is high exactly while presc holds all-ones
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      presc <= '0;
      tick  <= 1'b0;
    end else begin
      presc <= presc_nxt;
      tick  <= (presc_nxt == '1);
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [1:0]      mode_i;
    logic [1:0]      mode_q;
    logic [HP_W-1:0] hp;
    logic [BC_W-1:0] bc_i;
    state_t          state, state_nxt;
    logic [HP_W-1:0] phase, phase_nxt, phase_adv;
    logic [BC_W-1:0] rem, rem_nxt;
    logic            led_q, led_nxt;
    logic            busy_q, busy_nxt;
    logic            toggle;

    assign mode_i = mode[2*i +: 2];
    assign bc_i   = burst_cnt[BC_W*i +: BC_W];
    assign hp     = (half_period[HP_W*i +: HP_W] == '0) ? HP_W'(1)
                                                        : half_period[HP_W*i +: HP_W];
    // >= rather than == so a live shrink of hp below the current phase still toggles
    assign toggle    = tick && (phase >= hp - HP_W'(1));
    assign phase_adv = toggle ? '0 : phase + HP_W'(1);

    always_comb begin
      state_nxt = state;
      phase_nxt = phase;
      rem_nxt   = rem;
      led_nxt   = led_q;
      busy_nxt  = busy_q;
      if (mode_i != mode_q) begin
        state_nxt = S_IDLE;
        phase_nxt = '0;
        busy_nxt  = 1'b0;
        led_nxt   = (mode_i == M_ON);
      end else begin
        case (mode_q)
          M_OFF: begin
            state_nxt = S_IDLE;
            phase_nxt = '0;
            led_nxt   = 1'b0;
            busy_nxt  = 1'b0;
          end
          M_ON: begin
            state_nxt = S_IDLE;
            phase_nxt = '0;
            led_nxt   = 1'b1;
            busy_nxt  = 1'b0;
          end
          M_BLINK: begin
            busy_nxt = 1'b0;
            if (tick) begin
              phase_nxt = phase_adv;
              if (toggle) led_nxt = ~led_q;
            end
          end
          default: begin
            case (state)
              S_IDLE: begin
                led_nxt   = 1'b0;
                busy_nxt  = 1'b0;
                phase_nxt = '0;
                if (start[i] && (bc_i != '0)) begin
                  state_nxt = S_ON;
                  led_nxt   = 1'b1;
                  busy_nxt  = 1'b1;
                  rem_nxt   = bc_i;
                end
              end
              S_ON: begin
                if (tick) begin
                  phase_nxt = phase_adv;
                  if (toggle) begin
                    state_nxt = S_OFF;
                    led_nxt   = 1'b0;
                  end
                end
              end
              S_OFF: begin
                if (tick) begin
                  phase_nxt = phase_adv;
                  if (toggle) begin
                    if (rem == BC_W'(1)) begin
                      state_nxt = S_IDLE;
                      busy_nxt  = 1'b0;
                    end else begin
                      rem_nxt   = rem - BC_W'(1);
                      state_nxt = S_ON;
                      led_nxt   = 1'b1;
                    end
                  end
                end
              end
              default: state_nxt = S_IDLE;
            endcase
          end
        endcase
      end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        mode_q <= M_OFF;
        state  <= S_IDLE;
        phase  <= '0;
        rem    <= '0;
        led_q  <= 1'b0;
        busy_q <= 1'b0;
      end else begin
        mode_q <= mode_i;
        state  <= state_nxt;
        phase  <= phase_nxt;
        rem    <= rem_nxt;
        led_q  <= led_nxt;
        busy_q <= busy_nxt;
      end
    end

    assign led[i]  = led_q;
    assign busy[i] = busy_q;
  end

endmodule

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
- Multi-channel LED pattern generator, the parametrised successor of the single blinking-LED counter.
- A shared free-running prescaler produces a one-cycle tick.
- Each of NCH channels independently runs one of four modes: off, on, continuous blink, or N-pulse burst, each with its own half-period in ticks.
- Sits in Top between the KEY/SW controls (or a CSR block) and the LED pins.

Parameters:
- NCH, 8, number of LED channels.
- PRESC_W, 16, prescaler width; tick period = 2^PRESC_W sys_clk cycles (set to 2 in simulation benches).
- HP_W, 4, width of the per-channel half-period field, in ticks.
- BC_W, 4, width of the per-channel burst-count field.

Ports:
- sys_clk  in  1  system clock, 100 MHz.
- sys_rst_n  in  1  asynchronous active-low reset.
- mode  in  2*NCH  per-channel mode, channel i at [2i+1:2i]: 00 off, 01 on, 10 blink, 11 burst.
- half_period  in  HP_W*NCH  per-channel half-period in ticks; 0 is treated as 1.
- burst_cnt  in  BC_W*NCH  per-channel number of ON pulses per burst.
- start  in  NCH  per-channel single-cycle burst trigger.
- busy  out  NCH  burst in progress.
- led  out  NCH  LED drive, active high.
- tick  out  1  prescaler tick, for observability.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: all outputs registered and cleared asynchronously by sys_rst_n=0.
  - led=0, busy=0, tick=0, prescaler=0.
  - Every channel in IDLE with phase counter 0 and mode_q=00.
- Prescaler:
  - PRESC_W-bit counter, +1 every cycle, wraps to 0.
  - tick=1 for exactly the one cycle in which the counter equals all-ones, i.e. cycles 2^PRESC_W-1, 2*2^PRESC_W-1, ... after reset release.
- Per-channel mode register:
  - mode_q samples mode every cycle.
  - If mode != mode_q (mode change), the next cycle applies: phase=0, state=IDLE, busy=0, led = 1 if new mode is 01, else 0.
  - A mode change takes priority over tick and start in the same cycle.
- Effective half-period: hp = (half_period==0) ? 1 : half_period.
- Phase counter:
  - Advances only on tick cycles.
  - On a tick with phase==hp-1: phase←0 and a toggle event occurs; otherwise phase←phase+1.
  - The first interval after a start or mode change lasts exactly hp tick pulses (its wall-clock length depends on the prescaler alignment).
- Mode 00: led=0, busy=0, phase frozen at 0.
- Mode 01: led=1, busy=0, phase frozen at 0.
- Mode 10 (blink): led toggles on every toggle event; 50% duty; no busy.
- Mode 11 (burst) state machine:
  - IDLE: led=0, busy=0. start=1 and burst_cnt≠0 → ON_PH next cycle, with led=1, busy=1, phase=0, remaining=burst_cnt. start with burst_cnt=0 is a no-op.
  - ON_PH: on a toggle event → OFF_PH, led=0.
  - OFF_PH: on a toggle event:
    - if remaining==1 → IDLE, busy=0;
    - else remaining−1 → ON_PH, led=1.
  - start while busy=1 is ignored.
  - start in modes 00, 01 or 10 is ignored.
- Live inputs: half_period and burst_cnt changes mid-operation take effect at the next comparison or next start; no restart is triggered.
  - If hp is reduced below phase+1, the next tick forces a toggle event (phase≥hp-1 treated as a match).
- Reset mid-operation: led and busy drop immediately (asynchronously); the prescaler restarts from 0 on release.
- Channels are fully independent; simultaneous events on different channels do not interact.

Test Plan:
- Reset and tick cadence: PRESC_W=2, release reset → tick high at cycles 3, 7, 11 after release; all led/busy=0 throughout reset.
- Static modes: ch0 mode 00→01 → led[0]=1 one cycle later; 01→00 → led[0]=0 one cycle later; other channels unchanged.
- Blink: ch2 mode=10, hp=3, PRESC_W=2 → led[2] toggles every 3 ticks (12 cycles), 50% duty; hp=0 → toggles every tick (4 cycles).
- Burst: ch1 mode=11, hp=1, burst_cnt=2, start pulse → sequence per tick is high, low, high, low, then busy=0; exactly 2 rising edges; burst_cnt=0 with start → busy stays 0.
- Burst abuse:
  - second start during busy → still exactly burst_cnt pulses;
  - mode 11→10 mid-burst → busy=0 and led=0 next cycle, then blink from phase 0;
  - mode change and start in the same cycle → mode change wins.
- Async reset mid-blink (between clock edges) → led=0 immediately; after release, ticks resume at cycle 3.
